// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//
// Sequencing controller for the program counter register. Each cycle it
// picks the next PC source (sequential, redirect, exception vector or ERET
// return) and produces a PC write enable and a pipeline flush. It also owns
// the exception state (EPC, cause, status) and a sticky, maskable,
// rising-edge interrupt-pending register.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   stall                  : fetch stall, PC must not be written while high
//   pc_cur                 : current PC register value
//   redirect_req/_addr     : taken branch / jump and its target
//   exc_req, exc_code      : synchronous exception on pc_cur and its code
//   eret                   : ERET executing at pc_cur
//   irq[5:0]               : external interrupt lines (rising-edge)
//   cfg_we, cfg_status     : status write (bit0 IE, bits15:10 IM)
//   pc_next, pc_wen, flush : combinational PC load value / enable / kill
//   epc, cause, status     : registered exception state views
module pc_redirect_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0800,
    parameter logic [4:0]  RI_CODE    = 5'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] pc_cur,
    input  logic        redirect_req,
    input  logic [31:0] redirect_addr,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        eret,
    input  logic [5:0]  irq,
    input  logic        cfg_we,
    input  logic [31:0] cfg_status,
    output logic [31:0] pc_next,
    output logic        pc_wen,
    output logic        flush,
    output logic [31:0] epc,
    output logic [31:0] cause,
    output logic [31:0] status
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ENTRY  = 2'd1,
        RETURN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  code_q, code_d;
    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic [5:0]  im_q, im_d;
    logic [5:0]  pending_q, pending_d;
    logic [5:0]  irq_prev_q;

    logic [5:0]  irq_rise;
    logic [5:0]  irq_masked;
    logic [5:0]  irq_take;
    logic        irq_ok;
    logic        take_exc;
    logic [4:0]  take_code;
    logic [5:0]  pending_clr;

    // Only the used status fields are consumed; the rest are ignored.
    logic unused_cfg;
    assign unused_cfg = ^{cfg_status[31:16], cfg_status[9:1]};

    assign irq_rise   = irq & ~irq_prev_q;
    assign irq_masked = pending_q & im_q;
    // Isolate the lowest set bit: lowest index has highest priority.
    assign irq_take   = irq_masked & (~irq_masked + 6'd1);
    assign irq_ok     = ie_q & ~exl_q & (|irq_masked);

    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        code_d      = code_q;
        ie_d        = ie_q;
        exl_d       = exl_q;
        im_d        = im_q;
        pending_clr = 6'd0;
        take_exc    = 1'b0;
        take_code   = exc_code;
        pc_next     = pc_cur + 32'd4;
        pc_wen      = 1'b0;
        flush       = 1'b0;

        case (state_q)
            RUN: begin
                if (!stall) begin
                    if (exc_req) begin
                        take_exc  = 1'b1;
                        take_code = exc_code;
                    end else if (irq_ok) begin
                        epc_d       = pc_cur;
                        code_d      = 5'd0;
                        exl_d       = 1'b1;
                        pending_clr = irq_take;
                        flush       = 1'b1;
                        state_d     = ENTRY;
                    end else if (eret && exl_q) begin
                        flush   = 1'b1;
                        state_d = RETURN;
                    end else if (eret) begin
                        // ERET outside exception level is an illegal instruction.
                        take_exc  = 1'b1;
                        take_code = RI_CODE;
                    end else if (redirect_req) begin
                        pc_next = redirect_addr;
                        pc_wen  = 1'b1;
                    end else begin
                        pc_wen = 1'b1;
                    end

                    if (take_exc) begin
                        // Nested exception keeps the original EPC.
                        if (!exl_q) begin
                            epc_d = pc_cur;
                        end
                        code_d  = take_code;
                        exl_d   = 1'b1;
                        flush   = 1'b1;
                        state_d = ENTRY;
                    end
                end
            end
            ENTRY: begin
                pc_next = EXC_VECTOR;
                pc_wen  = ~stall;
                if (!stall) begin
                    state_d = RUN;
                end
            end
            RETURN: begin
                pc_next = epc_q;
                pc_wen  = ~stall;
                if (!stall) begin
                    exl_d   = 1'b0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (cfg_we) begin
            ie_d = cfg_status[0];
            im_d = cfg_status[15:10];
        end

        // A new edge wins over clearing the bit being taken.
        pending_d = (pending_q & ~pending_clr) | irq_rise;

        // No PC write or flush may escape while reset is being applied.
        if (reset) begin
            pc_wen = 1'b0;
            flush  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            epc_q      <= 32'd0;
            code_q     <= 5'd0;
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            im_q       <= 6'd0;
            pending_q  <= 6'd0;
            irq_prev_q <= 6'd0;
        end else begin
            state_q    <= state_d;
            epc_q      <= epc_d;
            code_q     <= code_d;
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            im_q       <= im_d;
            pending_q  <= pending_d;
            irq_prev_q <= irq;
        end
    end

    assign epc    = epc_q;
    assign cause  = {16'd0, pending_q, 3'd0, code_q, 2'd0};
    assign status = {16'd0, im_q, 8'd0, exl_q, ie_q};

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_req, exc_req, eret, cfg_we;
    logic [31:0] pc_cur, redirect_addr, cfg_status;
    logic [4:0]  exc_code;
    logic [5:0]  irq;
    logic [31:0] pc_next, epc, cause, status;
    logic        pc_wen, flush;

    always #5 clk = ~clk;

    pc_redirect_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_cur(pc_cur),
        .redirect_req(redirect_req), .redirect_addr(redirect_addr),
        .exc_req(exc_req), .exc_code(exc_code), .eret(eret), .irq(irq),
        .cfg_we(cfg_we), .cfg_status(cfg_status),
        .pc_next(pc_next), .pc_wen(pc_wen), .flush(flush),
        .epc(epc), .cause(cause), .status(status)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic [31:0] pc;
        logic        rr;
        logic [31:0] raddr;
        logic        exc;
        logic [4:0]  code;
        logic        eret;
        logic [5:0]  irq;
        logic        cfg_we;
        logic [31:0] cfg;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        wen;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] cause;
        logic [31:0] status;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: architectural exception state plus two "write owed"
    // flags describing which PC write is still due after an accept.
    logic [31:0] m_epc, n_epc;
    logic [4:0]  m_code, n_code;
    logic        m_ie, n_ie, m_exl, n_exl;
    logic [5:0]  m_im, n_im, m_pend, n_pend, m_prev, n_prev;
    bit          m_vec_due, n_vec_due, m_ret_due, n_ret_due;
    logic        e_wen, e_flush;
    logic [31:0] e_pc;

    function automatic stim_t S(logic rst, logic st, logic [31:0] pc, logic rr,
                                logic [31:0] ra, logic exc, logic [4:0] code,
                                logic er, logic [5:0] iq, logic cw, logic [31:0] cs);
        stim_t s;
        s.rst = rst; s.stall = st; s.pc = pc; s.rr = rr; s.raddr = ra;
        s.exc = exc; s.code = code; s.eret = er; s.irq = iq;
        s.cfg_we = cw; s.cfg = cs;
        return s;
    endfunction

    function automatic stim_t I(logic [31:0] pc);
        return S(0, 0, pc, 0, 0, 0, 0, 0, 6'd0, 0, 0);
    endfunction

    function automatic vec_t V(stim_t s, logic wen, logic fl, logic [31:0] pc,
                               logic [31:0] ep, logic [31:0] ca, logic [31:0] st);
        vec_t v;
        v.s = s; v.wen = wen; v.flush = fl; v.pc = pc;
        v.epc = ep; v.cause = ca; v.status = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic model_eval(input stim_t s);
        logic [5:0] rise, masked, clr;
        int         k;
        bit         do_enter;
        logic [4:0] ecode;
        n_epc = m_epc; n_code = m_code; n_ie = m_ie; n_exl = m_exl;
        n_im = m_im; n_pend = m_pend; n_prev = m_prev;
        n_vec_due = m_vec_due; n_ret_due = m_ret_due;
        e_wen = 0; e_flush = 0; e_pc = s.pc + 32'd4;
        rise = s.irq & ~m_prev;
        clr = 6'd0; do_enter = 0; ecode = 5'd0;
        if (s.rst) begin
            n_epc = 0; n_code = 0; n_ie = 0; n_exl = 0; n_im = 0;
            n_pend = 0; n_prev = 0; n_vec_due = 0; n_ret_due = 0;
        end else begin
            if (m_vec_due) begin
                e_pc = 32'h0000_0800; e_wen = !s.stall;
                if (!s.stall) n_vec_due = 0;
            end else if (m_ret_due) begin
                e_pc = m_epc; e_wen = !s.stall;
                if (!s.stall) begin n_ret_due = 0; n_exl = 0; end
            end else if (!s.stall) begin
                masked = m_pend & m_im;
                k = -1;
                for (int i = 0; i < 6; i++)
                    if (k < 0 && masked[i]) k = i;
                if (s.exc) begin
                    do_enter = 1; ecode = s.code;
                end else if (m_ie && !m_exl && k >= 0) begin
                    n_epc = s.pc; n_code = 0; n_exl = 1; clr[k] = 1'b1;
                    e_flush = 1; n_vec_due = 1;
                end else if (s.eret && m_exl) begin
                    e_flush = 1; n_ret_due = 1;
                end else if (s.eret) begin
                    do_enter = 1; ecode = 5'd10;
                end else if (s.rr) begin
                    e_pc = s.raddr; e_wen = 1;
                end else begin
                    e_wen = 1;
                end
                if (do_enter) begin
                    if (!m_exl) n_epc = s.pc;
                    n_code = ecode; n_exl = 1; e_flush = 1; n_vec_due = 1;
                end
            end
            if (s.cfg_we) begin n_ie = s.cfg[0]; n_im = s.cfg[15:10]; end
            n_pend = (m_pend & ~clr) | rise;
            n_prev = s.irq;
        end
    endtask

    // mode 0: no compare, 1: compare to vector, 2: compare to model
    task automatic run_cycle(input vec_t v, input int mode, input string tag);
        reset = v.s.rst; stall = v.s.stall; pc_cur = v.s.pc;
        redirect_req = v.s.rr; redirect_addr = v.s.raddr;
        exc_req = v.s.exc; exc_code = v.s.code; eret = v.s.eret;
        irq = v.s.irq; cfg_we = v.s.cfg_we; cfg_status = v.s.cfg;
        model_eval(v.s);
        #2;
        if (mode == 1) begin
            chk({tag, " pc_wen"}, {31'd0, pc_wen}, {31'd0, v.wen});
            chk({tag, " flush"}, {31'd0, flush}, {31'd0, v.flush});
            if (v.wen) chk({tag, " pc_next"}, pc_next, v.pc);
            chk({tag, " epc"}, epc, v.epc);
            chk({tag, " cause"}, cause, v.cause);
            chk({tag, " status"}, status, v.status);
        end else if (mode == 2) begin
            chk({tag, " pc_wen"}, {31'd0, pc_wen}, {31'd0, e_wen});
            chk({tag, " flush"}, {31'd0, flush}, {31'd0, e_flush});
            if (e_wen) chk({tag, " pc_next"}, pc_next, e_pc);
            chk({tag, " epc"}, epc, m_epc);
            chk({tag, " cause"}, cause, {16'd0, m_pend, 3'd0, m_code, 2'd0});
            chk({tag, " status"}, status, {16'd0, m_im, 8'd0, m_exl, m_ie});
        end
        if (mode != 0) begin
            n_total++;
            if ($isunknown(pc_next))
                $display("FAIL %s pc_next_known: got %08h expected no X", tag, pc_next);
            else
                n_pass++;
        end
        m_epc = n_epc; m_code = n_code; m_ie = n_ie; m_exl = n_exl;
        m_im = n_im; m_pend = n_pend; m_prev = n_prev;
        m_vec_due = n_vec_due; m_ret_due = n_ret_due;
        $display("cyc %s rst=%0b stall=%0b pc_cur=%08h pc_next=%08h wen=%0b flush=%0b epc=%08h cause=%08h status=%08h",
                 tag, reset, stall, pc_cur, pc_next, pc_wen, flush, epc, cause, status);
        @(posedge clk);
        #1;
    endtask

    vec_t  tab[16];
    stim_t rs;

    initial begin
        reset = 1; stall = 0; pc_cur = 0; redirect_req = 0; redirect_addr = 0;
        exc_req = 0; exc_code = 0; eret = 0; irq = 0; cfg_we = 0; cfg_status = 0;
        m_epc = 0; m_code = 0; m_ie = 0; m_exl = 0; m_im = 0; m_pend = 0; m_prev = 0;
        m_vec_due = 0; m_ret_due = 0;

        tab[0]  = V(S(1,0,32'h0,0,0,0,0,0,0,0,0),                 0,0,32'h0,        0,        0,        0);
        tab[1]  = V(I(32'h0000_1000),                             1,0,32'h0000_1004,0,        0,        0);
        tab[2]  = V(I(32'hFFFF_FFFC),                             1,0,32'h0000_0000,0,        0,        0);
        tab[3]  = V(S(0,1,32'h100,1,32'hCAFE_BABC,0,0,0,0,0,0),   0,0,32'h0,        0,        0,        0);
        tab[4]  = V(S(0,0,32'h100,1,32'hCAFE_BABC,0,0,0,0,0,0),   1,0,32'hCAFE_BABC,0,        0,        0);
        tab[5]  = V(S(0,0,32'h2000,0,0,1,5'd8,0,0,0,0),           0,1,32'h0,        0,        0,        0);
        tab[6]  = V(I(32'h0000_2000),                             1,0,32'h0000_0800,32'h2000, 32'h20,   32'h2);
        tab[7]  = V(S(0,0,32'h800,0,0,0,0,1,0,0,0),               0,1,32'h0,        32'h2000, 32'h20,   32'h2);
        tab[8]  = V(S(0,1,32'h800,0,0,0,0,0,0,0,0),               0,0,32'h0,        32'h2000, 32'h20,   32'h2);
        tab[9]  = V(I(32'h0000_0800),                             1,0,32'h0000_2000,32'h2000, 32'h20,   32'h2);
        tab[10] = V(I(32'h0000_2000),                             1,0,32'h0000_2004,32'h2000, 32'h20,   32'h0);
        tab[11] = V(S(0,0,32'h2004,0,0,0,0,1,0,0,0),              0,1,32'h0,        32'h2000, 32'h20,   32'h0);
        tab[12] = V(I(32'h0000_2004),                             1,0,32'h0000_0800,32'h2004, 32'h28,   32'h2);
        tab[13] = V(S(0,0,32'h800,0,0,1,5'd3,0,0,0,0),            0,1,32'h0,        32'h2004, 32'h28,   32'h2);
        tab[14] = V(S(1,0,32'h800,0,0,0,0,0,0,0,0),               0,0,32'h0,        32'h2004, 32'hC,    32'h2);
        tab[15] = V(I(32'h0000_0800),                             1,0,32'h0000_0804,0,        0,        0);

        @(posedge clk); #1;
        run_cycle(tab[0], 0, "init");
        for (int i = 0; i < 16; i++)
            run_cycle(tab[i], 1, $sformatf("tab%0d", i));

        // Interrupt sequence: irq1 and irq3 together, irq1 first, irq3 after ERET
        run_cycle(V(S(0,0,32'h3000,0,0,0,0,0,0,1,32'hFC01), 1,0,32'h3004,0,0,0), 1, "irq_cfg");
        run_cycle(V(S(0,0,32'h3004,0,0,0,0,0,6'b001010,0,0), 1,0,32'h3008,0,0,32'hFC01), 1, "irq_pulse");
        run_cycle(V(I(32'h3008), 0,1,0,0,32'h2800,32'hFC01), 1, "irq1_acc");
        run_cycle(V(I(32'h3008), 1,0,32'h800,32'h3008,32'h2000,32'hFC03), 1, "irq1_vec");
        run_cycle(V(I(32'h800), 1,0,32'h804,32'h3008,32'h2000,32'hFC03), 1, "irq3_masked_exl");
        run_cycle(V(S(0,0,32'h804,0,0,0,0,1,0,0,0), 0,1,0,32'h3008,32'h2000,32'hFC03), 1, "irq1_eret");
        run_cycle(V(I(32'h804), 1,0,32'h3008,32'h3008,32'h2000,32'hFC03), 1, "irq1_ret");
        run_cycle(V(I(32'h3008), 0,1,0,32'h3008,32'h2000,32'hFC01), 1, "irq3_acc");
        run_cycle(V(I(32'h3008), 1,0,32'h800,32'h3008,32'h0,32'hFC03), 1, "irq3_vec");
        run_cycle(V(S(0,0,32'h800,0,0,0,0,1,0,0,0), 0,1,0,32'h3008,32'h0,32'hFC03), 1, "irq3_eret");
        run_cycle(V(I(32'h800), 1,0,32'h3008,32'h3008,32'h0,32'hFC03), 1, "irq3_ret");
        // IE=0: both interrupts latch but are not taken
        run_cycle(V(S(0,0,32'h3008,0,0,0,0,0,6'b001010,1,32'hFC00), 1,0,32'h300C,32'h3008,32'h0,32'hFC01), 1, "ie0_pulse");
        run_cycle(V(I(32'h300C), 1,0,32'h3010,32'h3008,32'h2800,32'hFC00), 1, "ie0_hold");
        run_cycle(V(S(0,0,32'h3010,0,0,0,0,0,0,1,32'hFC01), 1,0,32'h3014,32'h3008,32'h2800,32'hFC00), 1, "ie0_pending");
        // exc + eligible irq + redirect together: exception wins, irqs stay pending
        run_cycle(V(S(0,0,32'h3014,1,32'h5000,1,5'd5,0,0,0,0), 0,1,0,32'h3008,32'h2800,32'hFC01), 1, "prio_acc");
        run_cycle(V(I(32'h3014), 1,0,32'h800,32'h3014,32'h2814,32'hFC03), 1, "prio_vec");
        run_cycle(V(I(32'h800), 1,0,32'h804,32'h3014,32'h2814,32'hFC03), 1, "prio_after");

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = $urandom;
            rs.rst    = ($urandom_range(0, 49) == 0);
            rs.stall  = ($urandom_range(0, 3) == 0);
            rs.pc     = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            rs.rr     = ($urandom_range(0, 2) == 0);
            rs.raddr  = $urandom & 32'hFFFF_FFFC;
            rs.exc    = ($urandom_range(0, 11) == 0);
            rs.code   = 5'($urandom_range(0, 31));
            rs.eret   = ($urandom_range(0, 7) == 0);
            rs.irq    = r[5:0] & r[11:6];
            rs.cfg_we = ($urandom_range(0, 9) == 0);
            rs.cfg    = $urandom;
            run_cycle(V(rs, 0, 0, 0, 0, 0, 0), 2, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
